// File: rtl/stream_packer_pkg.sv
// Shared definitions for the narrow-to-wide stream packer: FSM states,
// default geometry and the lane-counter width.
package stream_packer_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL
    } pack_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RATIO      = 4;
    localparam int LANE_W         = $clog2(DEF_RATIO);

    function automatic int lane_w(input int ratio);
        return $clog2(ratio);
    endfunction

endpackage

// File: rtl/stream_packer_if.sv
// Narrow input stream plus wide packed output stream of the packer.
// master = producer/consumer side, slave = the packer itself.
interface stream_packer_if
    import stream_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RATIO      = DEF_RATIO
);

    logic [DATA_WIDTH-1:0]       in_data;
    logic                        in_valid;
    logic                        in_last;
    logic                        in_ready;
    logic [DATA_WIDTH*RATIO-1:0] out_data;
    logic [RATIO-1:0]            out_keep;
    logic                        out_last;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_keep, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_keep, out_last, out_valid
    );

endinterface

// File: rtl/stream_packer.sv
// Packs RATIO narrow beats (or fewer, closed early by in_last) into one wide word with keep mask.
// Latency: out_valid rises the cycle after the closing beat; one beat/cycle sustained, no bubble.
// Backpressure: in_ready = !out_valid || out_ready; a stalled word holds its outputs stable.
module stream_packer
    import stream_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RATIO      = DEF_RATIO
) (
    input logic            clk,
    input logic            rst_n,
    stream_packer_if.slave bus
);

    localparam int WORD_W    = DATA_WIDTH * RATIO;
    localparam int LANE_BITS = lane_w(RATIO);
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(RATIO - 1);

    pack_state_t           state_q;
    pack_state_t           state_d;
    logic [LANE_BITS-1:0]  lane_cnt;
    logic [WORD_W-1:0]     data_q;
    logic [RATIO-1:0]      keep_q;
    logic                  last_q;
    logic                  beat_acc;
    logic                  word_acc;
    logic                  word_close;

    assign beat_acc   = bus.in_valid && bus.in_ready;
    assign word_acc   = bus.out_valid && bus.out_ready;
    assign word_close = beat_acc && (bus.in_last || (lane_cnt == LAST_LANE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY, FILL: begin
                if (beat_acc) begin
                    state_d = word_close ? FULL : FILL;
                end
            end
            FULL: begin
                // A beat accepted while draining starts the next word in lane 0.
                if (word_acc) begin
                    if (beat_acc) begin
                        state_d = word_close ? FULL : FILL;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        bus.out_valid = (state_q == FULL);
        bus.in_ready  = (state_q != FULL) || bus.out_ready;
        bus.out_data  = data_q;
        bus.out_keep  = keep_q;
        bus.out_last  = last_q;
    end

    // The output registers are the packing buffer; lane 0 clears the stale word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt <= '0;
            data_q   <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
        end else if (beat_acc) begin
            if (lane_cnt == '0) begin
                data_q <= {{(WORD_W - DATA_WIDTH){1'b0}}, bus.in_data};
                keep_q <= {{(RATIO - 1){1'b0}}, 1'b1};
            end else begin
                data_q[lane_cnt*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
                keep_q[lane_cnt]                          <= 1'b1;
            end
            last_q   <= bus.in_last;
            lane_cnt <= word_close ? '0 : lane_cnt + 1'b1;
        end
    end

endmodule
